kong_input_ctrl: RTL and testbench

KONG_INPUT_CTRL -- requirements
Module: kong_input_ctrl

---
 rtl/kong_pkg.sv | 18 +
 rtl/kong_key_debounce.sv | 34 +++
 rtl/kong_input_ctrl.sv | 69 ++++++
 tb/tb_kong_input_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/kong_pkg.sv
// kong_pkg: shared key encoding, action codes and cheat sequence for the Kong input controller.
package kong_pkg;
  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } kong_key;
  localparam kong_key NONE = '0;
  localparam logic [3:0] KEY_UP    = 4'h2;
  localparam logic [3:0] KEY_DOWN  = 4'h8;
  localparam logic [3:0] KEY_LEFT  = 4'h4;
  localparam logic [3:0] KEY_RIGHT = 4'h6;
  localparam logic [3:0] KEY_JUMP  = 4'h5;
  localparam logic [3:0][3:0] CHEAT_SEQ = {4'h9, 4'h7, 4'h3, 4'h1};
  typedef enum logic [1:0] {IDLE, GOT1, GOT2, GOT3} cheat_state;
  function automatic logic is_key(kong_key k, logic [3:0] c);
    return k.valid && k.code == c;
  endfunction
endpackage

// File: rtl/kong_key_debounce.sv
// kong_key_debounce: per-frame key sampling with a saturating match counter; key is the next stable value.
module kong_key_debounce
  import kong_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [3:0] keyPad,
  input  logic       keyIsPressed,
  output kong_key    key,
  output logic       new_press
);
  kong_key raw, cand, stable;
  logic [3:0] count, count_next;
  // key is combinational so the top can register outputs in the same frame the key settles
  always_comb begin
    raw = keyIsPressed ? kong_key'{1'b1, keyPad} : NONE;
    count_next = (raw != cand) ? 4'd0 : (count == 4'hF) ? count : count + 4'd1;
    key = (startOfFrame && count_next == 4'(DEBOUNCE_FRAMES - 1)) ? raw : stable;
    new_press = key.valid && key != stable;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      cand   <= NONE;
      count  <= '0;
      stable <= NONE;
    end else if (startOfFrame) begin
      cand   <= raw;
      count  <= count_next;
      stable <= key;
    end
endmodule

// File: rtl/kong_input_ctrl.sv
// kong_input_ctrl: debounced keypad to movement/jump requests plus a 1-3-7-9 cheat toggle with inter-press timeout.
module kong_input_ctrl
  import kong_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int CHEAT_TIMEOUT   = 120
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [3:0] keyPad,
  input  logic       keyIsPressed,
  output logic       ask_move_up,
  output logic       ask_move_down,
  output logic       ask_move_left,
  output logic       ask_move_right,
  output logic       ask_move_jump,
  output logic       cheat_mode
);
  kong_key key;
  logic new_press;
  cheat_state state;
  logic [7:0] timer;
  logic [8:0] timer_inc;
  logic timeout;
  kong_key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .keyPad(keyPad),
    .keyIsPressed(keyIsPressed),
    .key(key),
    .new_press(new_press)
  );
  always_comb begin
    timer_inc = {1'b0, timer} + 9'd1;
    timeout = timer_inc == 9'(CHEAT_TIMEOUT);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      ask_move_up    <= 1'b0;
      ask_move_down  <= 1'b0;
      ask_move_left  <= 1'b0;
      ask_move_right <= 1'b0;
      ask_move_jump  <= 1'b0;
      cheat_mode     <= 1'b0;
      state          <= IDLE;
      timer          <= '0;
    end else if (startOfFrame) begin
      ask_move_up    <= is_key(key, KEY_UP);
      ask_move_down  <= is_key(key, KEY_DOWN);
      ask_move_left  <= is_key(key, KEY_LEFT);
      ask_move_right <= is_key(key, KEY_RIGHT);
      ask_move_jump  <= new_press && is_key(key, KEY_JUMP);
      // a press in the timeout frame wins over the timeout
      if (new_press) begin
        timer <= '0;
        if (key.code == CHEAT_SEQ[state]) begin
          state <= (state == GOT3) ? IDLE : cheat_state'(state + 2'd1);
          if (state == GOT3) cheat_mode <= ~cheat_mode;
        end else begin
          state <= (key.code == CHEAT_SEQ[0]) ? GOT1 : IDLE;
        end
      end else if (state != IDLE) begin
        timer <= timeout ? 8'd0 : timer_inc[7:0];
        if (timeout) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_kong_input_ctrl.sv
// tb_kong_input_ctrl: directed and random frames checked every cycle against a frame-level behavioural model.
module tb_kong_input_ctrl;
  localparam int DF = 2;
  localparam int TO = 120;
  logic clk = 0, resetN = 0, startOfFrame = 0, keyIsPressed = 0;
  logic [3:0] keyPad = 0;
  logic up, down, left, right, jump, cheat;
  int errors = 0, checks = 0;
  bit live = 0;
  int m_last, m_run, m_stable, m_prog, m_since;
  logic e_up, e_down, e_left, e_right, e_jump, e_cheat;
  int seq[4] = '{1, 3, 7, 9};
  int keys[10] = '{1, 3, 7, 9, 2, 4, 5, 6, 8, 0};
  int njump, nleft;

  kong_input_ctrl #(.DEBOUNCE_FRAMES(DF), .CHEAT_TIMEOUT(TO)) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .keyPad(keyPad),
    .keyIsPressed(keyIsPressed),
    .ask_move_up(up),
    .ask_move_down(down),
    .ask_move_left(left),
    .ask_move_right(right),
    .ask_move_jump(jump),
    .cheat_mode(cheat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (live) begin
      check("up", int'(up), int'(e_up));
      check("down", int'(down), int'(e_down));
      check("left", int'(left), int'(e_left));
      check("right", int'(right), int'(e_right));
      check("jump", int'(jump), int'(e_jump));
      check("cheat", int'(cheat), int'(e_cheat));
    end

  task automatic model_reset();
    m_last = 0;
    m_run = 1;
    m_stable = 0;
    m_prog = 0;
    m_since = 0;
    {e_up, e_down, e_left, e_right, e_jump, e_cheat} = '0;
  endtask

  // keys encoded as 16+code, released as 0; stable = value seen on the last DF samples
  task automatic model_step(input logic p, input logic [3:0] k);
    int raw, prev, code;
    bit np;
    raw = p ? 16 + int'(k) : 0;
    if (raw == m_last) m_run++;
    else begin
      m_last = raw;
      m_run = 1;
    end
    prev = m_stable;
    if (m_run >= DF) m_stable = m_last;
    np = m_stable != prev && m_stable != 0;
    e_up = m_stable == 18;
    e_down = m_stable == 24;
    e_left = m_stable == 20;
    e_right = m_stable == 22;
    e_jump = np && m_stable == 21;
    if (np) begin
      code = m_stable - 16;
      m_since = 0;
      if (code == seq[m_prog]) begin
        m_prog++;
        if (m_prog == 4) begin
          e_cheat = !e_cheat;
          m_prog = 0;
        end
      end else m_prog = (code == 1) ? 1 : 0;
    end else if (m_prog != 0) begin
      m_since++;
      if (m_since >= TO) begin
        m_prog = 0;
        m_since = 0;
      end
    end
  endtask

  task automatic frame(input logic p, input logic [3:0] k);
    int gap;
    keyIsPressed = p;
    keyPad = k;
    startOfFrame = 1;
    @(posedge clk);
    #1;
    startOfFrame = 0;
    model_step(p, k);
    if (jump) njump++;
    if (left) nleft++;
    gap = $urandom_range(1, 3);
    keyPad = 4'($urandom);
    keyIsPressed = 1'($urandom);
    repeat (gap) begin
      @(posedge clk);
      #1;
      keyPad = 4'($urandom);
      keyIsPressed = 1'($urandom);
    end
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    repeat (n) frame(1, k);
  endtask

  task automatic idle(input int n);
    repeat (n) frame(0, 0);
  endtask

  task automatic press(input logic [3:0] k);
    hold(k, 3);
    idle(2);
  endtask

  initial begin
    int k, n;
    logic p;
    model_reset();
    live = 1;
    repeat (3) @(posedge clk);
    #3 resetN = 1;
    @(posedge clk);
    #1;
    check("reset_cheat", int'(cheat), 0);
    frame(1, 6);
    check("r031_first_sample", int'(right), 0);
    frame(1, 6);
    check("r031_second_sample", int'(right), 1);
    check("r031_no_up", int'(up), 0);
    hold(6, 3);
    idle(1);
    check("r031_release_pending", int'(right), 1);
    idle(1);
    check("r031_release_stable", int'(right), 0);
    nleft = 0;
    repeat (5) begin
      frame(1, 4);
      frame(0, 0);
    end
    check("r032_left_frames", nleft, 0);
    idle(2);
    njump = 0;
    hold(5, 20);
    idle(2);
    hold(5, 3);
    idle(2);
    check("r033_jump_frames", njump, 2);
    foreach (seq[i]) press(4'(seq[i]));
    check("r034_on", int'(cheat), 1);
    foreach (seq[i]) press(4'(seq[i]));
    check("r034_off", int'(cheat), 0);
    press(1);
    press(3);
    idle(130);
    press(7);
    press(9);
    check("r035_timeout", int'(cheat), 0);
    press(1);
    press(1);
    press(3);
    press(7);
    press(9);
    check("r035_repeat1", int'(cheat), 1);
    press(1);
    press(3);
    hold(2, 3);
    check("r036_up_before", int'(up), 1);
    #2 resetN = 0;
    model_reset();
    #1;
    check("r036_up_reset", int'(up), 0);
    check("r036_cheat_reset", int'(cheat), 0);
    #10 resetN = 1;
    @(posedge clk);
    #1;
    keyIsPressed = 1;
    keyPad = 2;
    frame(1, 2);
    check("r036_one_sample", int'(up), 0);
    frame(1, 2);
    check("r036_two_samples", int'(up), 1);
    repeat (200) begin
      k = keys[$urandom_range(0, 9)];
      n = $urandom_range(1, 4);
      p = (k != 0) && ($urandom_range(0, 4) != 0);
      repeat (n) frame(p, 4'(k));
    end
    live = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
